// File: rtl/jk_bank_sequencer_if.sv
// Command/response bundle between the control logic and jk_bank_sequencer.
// master issues commands and collects done/err/result; slave is the sequencer.
interface jk_bank_sequencer_if #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [WIDTH-1:0]  cmd_data;
    logic [STEP_W-1:0] cmd_steps;
    logic              done;
    logic              err;
    logic [WIDTH-1:0]  result;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_steps,
        input  cmd_ready, done, err, result
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_steps,
        output cmd_ready, done, err, result
    );
endinterface

// File: rtl/jk_bank_sequencer.sv
// Command-driven J/K controller for an external JK flip-flop bank;
// returns the bank Q with a one-cycle done pulse after each command.
module jk_bank_sequencer #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    jk_bank_sequencer_if.slave cmd,
    input  logic               abort,
    input  logic [WIDTH-1:0]   jk_q,
    output logic [WIDTH-1:0]   jk_j,
    output logic [WIDTH-1:0]   jk_k
);
    localparam logic [2:0] OP_LOAD   = 3'b001;
    localparam logic [2:0] OP_CLEAR  = 3'b010;
    localparam logic [2:0] OP_SET    = 3'b011;
    localparam logic [2:0] OP_TOGGLE = 3'b100;
    localparam logic [2:0] OP_UP     = 3'b101;
    localparam logic [2:0] OP_DOWN   = 3'b110;
    localparam logic [2:0] OP_ILL    = 3'b111;

    typedef enum logic [1:0] {IDLE, APPLY, COUNT, DONE} state_t;

    state_t            state, state_nx;
    logic [2:0]        op_q;
    logic [WIDTH-1:0]  data_q;
    logic [WIDTH-1:0]  res_q;
    logic [STEP_W-1:0] rem_q, rem_nx;
    logic [WIDTH-1:0]  carry;
    logic              run;
    logic              accept;

    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign cmd.cmd_ready = (state == IDLE);
    assign cmd.done      = (state == DONE);
    assign cmd.err       = cmd.done && (op_q == OP_ILL);
    // The bank updates on the edge entering DONE, so Q is already final here
    assign cmd.result    = cmd.done ? jk_q : res_q;

    always_comb begin
        state_nx = state;
        rem_nx   = rem_q;
        jk_j     = '0;
        jk_k     = '0;
        carry    = '0;
        run      = 1'b1;
        unique case (state)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    unique case (cmd.cmd_op)
                        OP_LOAD, OP_CLEAR, OP_SET, OP_TOGGLE:
                            state_nx = APPLY;
                        OP_UP, OP_DOWN: begin
                            if (cmd.cmd_steps != '0) begin
                                state_nx = COUNT;
                                rem_nx   = cmd.cmd_steps;
                            end else begin
                                state_nx = DONE;
                            end
                        end
                        default: state_nx = DONE;
                    endcase
                end
            end
            APPLY: begin
                state_nx = DONE;
                unique case (op_q)
                    OP_LOAD: begin
                        jk_j = data_q;
                        jk_k = ~data_q;
                    end
                    OP_CLEAR:  jk_k = '1;
                    OP_SET:    jk_j = '1;
                    OP_TOGGLE: begin
                        jk_j = data_q;
                        jk_k = data_q;
                    end
                    default: ;
                endcase
            end
            COUNT: begin
                if (abort) begin
                    state_nx = DONE;
                end else begin
                    // Ripple enable: bit i toggles when all lower bits
                    // are 1 (up) or all are 0 (down)
                    for (int i = 0; i < WIDTH; i++) begin
                        carry[i] = run;
                        run = run & ((op_q == OP_UP) ? jk_q[i] : ~jk_q[i]);
                    end
                    jk_j   = carry;
                    jk_k   = carry;
                    rem_nx = rem_q - 1'b1;
                    if (rem_q == STEP_W'(1))
                        state_nx = DONE;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            op_q   <= '0;
            data_q <= '0;
            rem_q  <= '0;
            res_q  <= '0;
        end else begin
            state <= state_nx;
            rem_q <= rem_nx;
            if (accept) begin
                op_q   <= cmd.cmd_op;
                data_q <= cmd.cmd_data;
            end
            if (state == DONE)
                res_q <= jk_q;
        end
    end
endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Bench for jk_bank_sequencer: JK bank model, directed sequence,
// async reset mid-count, then randomized commands against a queue model.
module tb_jk_bank_sequencer;
    localparam int W  = 4;
    localparam int SW = 8;

    typedef struct {
        logic         ready;
        logic [W-1:0] j;
        logic [W-1:0] k;
        logic         done;
        logic         err;
        logic [W-1:0] res;
    } exp_t;

    typedef struct {
        logic [2:0]    op;
        logic [W-1:0]  d;
        logic [SW-1:0] s;
        int            ab;
    } cmd_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         abort = 1'b0;
    logic [W-1:0] jk_q, jk_j, jk_k;
    logic [W-1:0] bank = '0;

    int n_tests = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    logic [W-1:0] mq = '0;
    logic [W-1:0] last_res = '0;
    logic         last_err = 1'b0;
    exp_t exp_q[$];
    cmd_t cq[$];

    jk_bank_sequencer_if #(.WIDTH(W), .STEP_W(SW)) cmd ();

    jk_bank_sequencer #(.WIDTH(W), .STEP_W(SW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cmd     (cmd),
        .abort   (abort),
        .jk_q    (jk_q),
        .jk_j    (jk_j),
        .jk_k    (jk_k)
    );

    always #5 clk = ~clk;

    // External JK bank: Q+ = J&~Q | ~K&Q, no reset
    always @(posedge clk) bank <= (jk_j & ~bank) | (~jk_k & bank);
    assign jk_q = bank;

    task automatic chk1(input string name, input logic act, input logic expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, expv, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t rec(input logic rdy);
        exp_t e;
        e.ready = rdy;
        e.j = '0;
        e.k = '0;
        e.done = 1'b0;
        e.err = 1'b0;
        e.res = '0;
        return e;
    endfunction

    // Expected per-cycle outputs for one command, from accept onward
    task automatic plan(input cmd_t c, output int len);
        exp_t e;
        logic [W-1:0] nq;
        len = 0;
        e = rec(1'b0);
        nq = mq;
        case (c.op)
            3'd1, 3'd2, 3'd3, 3'd4: begin
                case (c.op)
                    3'd1: begin e.j = c.d; e.k = ~c.d; nq = c.d; end
                    3'd2: begin e.k = '1; nq = '0; end
                    3'd3: begin e.j = '1; nq = '1; end
                    default: begin e.j = c.d; e.k = c.d; nq = mq ^ c.d; end
                endcase
                exp_q.push_back(e);
                len++;
                mq = nq;
            end
            3'd5, 3'd6: begin
                for (int i = 1; i <= int'(c.s); i++) begin
                    e = rec(1'b0);
                    if (i == c.ab) begin
                        exp_q.push_back(e);
                        len++;
                        break;
                    end
                    nq = (c.op == 3'd5) ? mq + 1'b1 : mq - 1'b1;
                    e.j = mq ^ nq;
                    e.k = mq ^ nq;
                    exp_q.push_back(e);
                    len++;
                    mq = nq;
                end
            end
            default: ;
        endcase
        e = rec(1'b0);
        e.done = 1'b1;
        e.err = (c.op == 3'd7);
        e.res = mq;
        exp_q.push_back(e);
        len++;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            e = rec(1'b1);
            if (exp_q.size() > 0)
                e = exp_q.pop_front();
            chk1("cmd_ready", cmd.cmd_ready, e.ready);
            chkw("jk_j", jk_j, e.j);
            chkw("jk_k", jk_k, e.k);
            chk1("done", cmd.done, e.done);
            if (e.done) begin
                chk1("err", cmd.err, e.err);
                chkw("result", cmd.result, e.res);
                last_res = cmd.result;
                last_err = cmd.err;
            end
        end
    end

    task automatic drive(input cmd_t c);
        cmd.cmd_valid = 1'b1;
        cmd.cmd_op = c.op;
        cmd.cmd_data = c.d;
        cmd.cmd_steps = c.s;
    endtask

    task automatic idle_bus();
        cmd.cmd_valid = 1'b0;
        cmd.cmd_op = 3'($urandom);
        cmd.cmd_data = W'($urandom);
        cmd.cmd_steps = SW'($urandom);
    endtask

    task automatic run_all(input bit rnd);
        cmd_t c;
        int len;
        bit held;
        bit cnt;
        held = 1'b0;
        while (cq.size() > 0) begin
            c = cq.pop_front();
            cnt = (c.op == 3'd5 || c.op == 3'd6) && c.s != '0;
            if (!held)
                drive(c);
            abort = rnd ? 1'($urandom) : 1'b0;
            @(posedge clk);
            #1;
            plan(c, len);
            held = rnd && cq.size() > 0 && $urandom_range(0, 3) == 0;
            if (held)
                drive(cq[0]);
            else
                idle_bus();
            for (int i = 1; i <= len; i++) begin
                if (cnt)
                    abort = (i == c.ab);
                else
                    abort = rnd ? 1'($urandom) : 1'b0;
                @(posedge clk);
                #1;
            end
            abort = 1'b0;
            if (rnd && !held) begin
                repeat ($urandom_range(0, 2)) begin
                    abort = 1'($urandom);
                    @(posedge clk);
                    #1;
                end
                abort = 1'b0;
            end
        end
    endtask

    task automatic one(input logic [2:0] op, input logic [W-1:0] d,
                       input logic [SW-1:0] s, input int ab);
        cmd_t c;
        c.op = op;
        c.d = d;
        c.s = s;
        c.ab = ab;
        cq.push_back(c);
        run_all(1'b0);
    endtask

    task automatic pin(input string name, input logic [W-1:0] lit, input logic lerr);
        chkw({name, " model"}, mq, lit);
        chkw({name, " result"}, last_res, lit);
        chk1({name, " err"}, last_err, lerr);
    endtask

    initial begin
        cmd_t c;
        idle_bus();
        #1 reset_n = 1'b0;
        #2;
        chk1("reset cmd_ready", cmd.cmd_ready, 1'b1);
        chkw("reset jk_j", jk_j, '0);
        chkw("reset jk_k", jk_k, '0);
        chk1("reset done", cmd.done, 1'b0);
        chk1("reset err", cmd.err, 1'b0);
        chkw("reset result", cmd.result, '0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;

        one(3'd1, 4'b1010, '0, 0);
        pin("load", 4'b1010, 1'b0);
        one(3'd2, '0, '0, 0);
        pin("clear", 4'b0000, 1'b0);
        one(3'd3, '0, '0, 0);
        pin("set", 4'b1111, 1'b0);
        one(3'd4, 4'b0110, '0, 0);
        pin("toggle", 4'b1001, 1'b0);
        one(3'd1, 4'b1110, '0, 0);
        one(3'd5, '0, 8'd3, 0);
        pin("count_up wrap", 4'b0001, 1'b0);
        one(3'd6, '0, 8'd2, 0);
        pin("count_down wrap", 4'b1111, 1'b0);
        one(3'd1, 4'b0000, '0, 0);
        one(3'd5, '0, 8'd10, 4);
        pin("count abort", 4'b0011, 1'b0);
        one(3'd7, 4'b0101, 8'd9, 0);
        pin("illegal op", 4'b0011, 1'b1);
        one(3'd5, 4'b1100, 8'd0, 0);
        pin("count zero", 4'b0011, 1'b0);

        // Asynchronous reset in the middle of a long count
        c.op = 3'd5;
        c.d = '0;
        c.s = 8'd50;
        c.ab = 0;
        drive(c);
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        idle_bus();
        repeat (5) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chkw("async rst jk_j", jk_j, '0);
        chkw("async rst jk_k", jk_k, '0);
        chk1("async rst cmd_ready", cmd.cmd_ready, 1'b1);
        chk1("async rst done", cmd.done, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk1("rst hold done", cmd.done, 1'b0);
        end
        mq = mq + W'(5);
        chkw("rst bank hold", jk_q, mq);
        chkw("rst result", cmd.result, '0);
        reset_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;

        for (int n = 0; n < 150; n++) begin
            c.op = 3'($urandom);
            c.d = W'($urandom);
            if ($urandom_range(0, 9) == 0)
                c.s = SW'($urandom);
            else
                c.s = SW'($urandom_range(0, 12));
            c.ab = 0;
            if ((c.op == 3'd5 || c.op == 3'd6) && c.s != '0 && $urandom_range(0, 2) == 0)
                c.ab = int'($urandom_range(1, int'(c.s)));
            cq.push_back(c);
        end
        run_all(1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk1("final exp queue drained", exp_q.size() == 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
